// File: rtl/nanorv32_tcm_share_arb_if.sv
// Bus bundle between the CPU code/data ports, the shared TCM and the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever sits around it (CPU ports and the TCM controller).
interface nanorv32_tcm_share_arb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // code fetch port
  logic [31:0]           cpu_codeif_addr;
  logic                  cpu_codeif_req;
  logic [DATA_WIDTH-1:0] codeif_cpu_rdata;
  logic                  codeif_cpu_early_ready;
  logic                  codeif_cpu_ready_r;
  // data load/store port
  logic [31:0]           cpu_dataif_addr;
  logic [DATA_WIDTH-1:0] cpu_dataif_wdata;
  logic [3:0]            cpu_dataif_bytesel;
  logic                  cpu_dataif_req;
  logic [DATA_WIDTH-1:0] dataif_cpu_rdata;
  logic                  dataif_cpu_early_ready;
  logic                  dataif_cpu_ready_r;
  // shared TCM
  logic [ADDR_WIDTH-1:0] tcm_addr;
  logic [DATA_WIDTH-1:0] tcm_din;
  logic [3:0]            tcm_bytesel;
  logic                  tcm_en;
  logic [DATA_WIDTH-1:0] tcm_dout;
  logic                  tcm_ready_nxt;

  modport slave (
    input  cpu_codeif_addr, cpu_codeif_req,
    output codeif_cpu_rdata, codeif_cpu_early_ready, codeif_cpu_ready_r,
    input  cpu_dataif_addr, cpu_dataif_wdata, cpu_dataif_bytesel, cpu_dataif_req,
    output dataif_cpu_rdata, dataif_cpu_early_ready, dataif_cpu_ready_r,
    output tcm_addr, tcm_din, tcm_bytesel, tcm_en,
    input  tcm_dout, tcm_ready_nxt
  );

  modport master (
    output cpu_codeif_addr, cpu_codeif_req,
    input  codeif_cpu_rdata, codeif_cpu_early_ready, codeif_cpu_ready_r,
    output cpu_dataif_addr, cpu_dataif_wdata, cpu_dataif_bytesel, cpu_dataif_req,
    input  dataif_cpu_rdata, dataif_cpu_early_ready, dataif_cpu_ready_r,
    input  tcm_addr, tcm_din, tcm_bytesel, tcm_en,
    output tcm_dout, tcm_ready_nxt
  );
endinterface

// File: rtl/nanorv32_tcm_share_arb.sv
// Arbiter sharing one single-port TCM between the CPU fetch and load/store ports.
// Data has priority; code is forced through after STARVE_MAX denied cycles.
// A wait-stated access keeps the grant locked until the TCM reports completion.
// Optional feature macro: NANORV32_TCM_ARB_STATS_EN adds a saturating
// arb_conflict_cnt output counting cycles where code waits on a data request.
module nanorv32_tcm_share_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  nanorv32_tcm_share_arb_if.slave    bus
`ifdef NANORV32_TCM_ARB_STATS_EN
  ,
  output logic [15:0]                arb_conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    OWNER_IDLE      = 2'd0,
    OWNER_BUSY_CODE = 2'd1,
    OWNER_BUSY_DATA = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_code_q, rsp_code_d;
  logic       rsp_data_q, rsp_data_d;
  logic       sel_code_s, sel_data_s;
  logic       code_early_s, data_early_s;

  // Only the low ADDR_WIDTH address bits reach the TCM; the rest are dropped.
  logic unused_addr_hi_s;
  assign unused_addr_hi_s = ^{bus.cpu_codeif_addr[31:ADDR_WIDTH],
                              bus.cpu_dataif_addr[31:ADDR_WIDTH]};

  // Arbitration: decide which requester drives the TCM this cycle.
  always_comb begin
    sel_code_s = 1'b0;
    sel_data_s = 1'b0;
    case (owner_q)
      OWNER_IDLE: begin
        if (bus.cpu_codeif_req &&
            (!bus.cpu_dataif_req || (starve_cnt_q == STARVE_MAX_C))) begin
          sel_code_s = 1'b1;
        end else if (bus.cpu_dataif_req) begin
          sel_data_s = 1'b1;
        end else begin
          sel_code_s = 1'b0;
          sel_data_s = 1'b0;
        end
      end
      OWNER_BUSY_CODE: sel_code_s = 1'b1;
      OWNER_BUSY_DATA: sel_data_s = 1'b1;
      default: begin
        sel_code_s = 1'b0;
        sel_data_s = 1'b0;
      end
    endcase
  end

  // Completion strobes: only the requester currently driving the TCM can finish.
  always_comb begin
    code_early_s = sel_code_s & bus.tcm_ready_nxt;
    data_early_s = sel_data_s & bus.tcm_ready_nxt;
  end

  // Next owner: lock onto the driving requester until its access completes.
  always_comb begin
    owner_d = OWNER_IDLE;
    if (sel_code_s && !bus.tcm_ready_nxt) begin
      owner_d = OWNER_BUSY_CODE;
    end else if (sel_data_s && !bus.tcm_ready_nxt) begin
      owner_d = OWNER_BUSY_DATA;
    end else begin
      owner_d = OWNER_IDLE;
    end
  end

  // Owner state register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // TCM drive and requester strobes; the code path never writes.
  always_comb begin
    bus.tcm_en                 = 1'b0;
    bus.tcm_addr               = {ADDR_WIDTH{1'b0}};
    bus.tcm_din                = {DATA_WIDTH{1'b0}};
    bus.tcm_bytesel            = 4'b0000;
    bus.codeif_cpu_early_ready = code_early_s;
    bus.dataif_cpu_early_ready = data_early_s;
    if (sel_code_s) begin
      bus.tcm_en   = 1'b1;
      bus.tcm_addr = bus.cpu_codeif_addr[ADDR_WIDTH-1:0];
    end else if (sel_data_s) begin
      bus.tcm_en      = 1'b1;
      bus.tcm_addr    = bus.cpu_dataif_addr[ADDR_WIDTH-1:0];
      bus.tcm_din     = bus.cpu_dataif_wdata;
      bus.tcm_bytesel = bus.cpu_dataif_bytesel;
    end else begin
      bus.tcm_en = 1'b0;
    end
  end

  // Starvation counter: counts denied code cycles, saturating at STARVE_MAX.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.cpu_codeif_req || sel_code_s) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q == STARVE_MAX_C) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Response tracking: remember which port owns next cycle's TCM read data.
  always_comb begin
    rsp_code_d = code_early_s;
    rsp_data_d = data_early_s;
  end

  // Starvation and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rsp_code_q   <= 1'b0;
      rsp_data_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_code_q   <= rsp_code_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Response routing: TCM read data goes only to the port that completed.
  always_comb begin
    bus.codeif_cpu_ready_r = rsp_code_q;
    bus.dataif_cpu_ready_r = rsp_data_q;
    if (rsp_code_q) begin
      bus.codeif_cpu_rdata = bus.tcm_dout;
    end else begin
      bus.codeif_cpu_rdata = {DATA_WIDTH{1'b0}};
    end
    if (rsp_data_q) begin
      bus.dataif_cpu_rdata = bus.tcm_dout;
    end else begin
      bus.dataif_cpu_rdata = {DATA_WIDTH{1'b0}};
    end
  end

`ifdef NANORV32_TCM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict_s;

  // Conflict cycle: code is asking, not finishing, and data is also asking.
  always_comb begin
    conflict_s     = bus.cpu_codeif_req & ~code_early_s & bus.cpu_dataif_req;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Saturating conflict counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign arb_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_nanorv32_tcm_share_arb.sv
// Directed bench for nanorv32_tcm_share_arb. Inputs change on the falling edge;
// outputs are compared 1 ns later, well away from the rising (active) edge.
module tb_nanorv32_tcm_share_arb;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  nanorv32_tcm_share_arb_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

`ifdef NANORV32_TCM_ARB_STATS_EN
  logic [15:0] arb_conflict_cnt;
`endif

  nanorv32_tcm_share_arb #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .STARVE_MAX(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef NANORV32_TCM_ARB_STATS_EN
    ,
    .arb_conflict_cnt (arb_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: apply on the falling edge, settle 1 ns.
  task automatic drive(input logic r, input logic creq, input logic [31:0] caddr,
                       input logic dreq, input logic [31:0] daddr,
                       input logic [31:0] wdata, input logic [3:0] bsel,
                       input logic rdy, input logic [31:0] dout);
    @(negedge clk);
    rst                    = r;
    bus.cpu_codeif_req     = creq;
    bus.cpu_codeif_addr    = caddr;
    bus.cpu_dataif_req     = dreq;
    bus.cpu_dataif_addr    = daddr;
    bus.cpu_dataif_wdata   = wdata;
    bus.cpu_dataif_bytesel = bsel;
    bus.tcm_ready_nxt      = rdy;
    bus.tcm_dout           = dout;
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst                    = 1'b1;
    bus.cpu_codeif_req     = 1'b0;
    bus.cpu_codeif_addr    = 32'h0;
    bus.cpu_dataif_req     = 1'b0;
    bus.cpu_dataif_addr    = 32'h0;
    bus.cpu_dataif_wdata   = 32'h0;
    bus.cpu_dataif_bytesel = 4'h0;
    bus.tcm_ready_nxt      = 1'b0;
    bus.tcm_dout           = 32'h0;

    // Reset state
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF);
    chk("rst_code_ready_r", 32'(bus.codeif_cpu_ready_r), 32'h0);
    chk("rst_data_ready_r", 32'(bus.dataif_cpu_ready_r), 32'h0);
    chk("rst_code_rdata",   bus.codeif_cpu_rdata, 32'h0);
    chk("rst_data_rdata",   bus.dataif_cpu_rdata, 32'h0);
    chk("idle_tcm_en",      32'(bus.tcm_en), 32'h0);
    chk("idle_tcm_addr",    32'(bus.tcm_addr), 32'h0);

    // 1: code only, zero wait, three back-to-back fetches
    drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t1_en0",     32'(bus.tcm_en), 32'h1);
    chk("t1_addr0",   32'(bus.tcm_addr), 32'h010);
    chk("t1_din0",    bus.tcm_din, 32'h0);
    chk("t1_bsel0",   32'(bus.tcm_bytesel), 32'h0);
    chk("t1_cearly0", 32'(bus.codeif_cpu_early_ready), 32'h1);
    chk("t1_dearly0", 32'(bus.dataif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA000_0010);
    chk("t1_addr1",   32'(bus.tcm_addr), 32'h014);
    chk("t1_rdyr1",   32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t1_rdata1",  bus.codeif_cpu_rdata, 32'hA000_0010);
    drive(1'b0, 1'b1, 32'h0000_0018, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA000_0014);
    chk("t1_addr2",   32'(bus.tcm_addr), 32'h018);
    chk("t1_rdyr2",   32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t1_rdata2",  bus.codeif_cpu_rdata, 32'hA000_0014);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA000_0018);
    chk("t1_rdyr3",   32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t1_rdata3",  bus.codeif_cpu_rdata, 32'hA000_0018);
    chk("t1_drdata3", bus.dataif_cpu_rdata, 32'h0);
    chk("t1_en3",     32'(bus.tcm_en), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h5555_5555);
    chk("t1_rdyr4",   32'(bus.codeif_cpu_ready_r), 32'h0);
    chk("t1_rdata4",  bus.codeif_cpu_rdata, 32'h0);

    // 2: simultaneous requests, data wins 3 cycles then code is forced once
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h2000_0200, 32'h0, 4'h0, 1'b1, 32'h0);
      chk($sformatf("t2_addr_c%0d", i),  32'(bus.tcm_addr), 32'h200);
      chk($sformatf("t2_dearly_c%0d", i), 32'(bus.dataif_cpu_early_ready), 32'h1);
      chk($sformatf("t2_cearly_c%0d", i), 32'(bus.codeif_cpu_early_ready), 32'h0);
    end
    drive(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h2000_0200, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t2_addr_c3",   32'(bus.tcm_addr), 32'h020);
    chk("t2_cearly_c3", 32'(bus.codeif_cpu_early_ready), 32'h1);
    chk("t2_dearly_c3", 32'(bus.dataif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h2000_0200, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t2_addr_c4",   32'(bus.tcm_addr), 32'h200);
    chk("t2_dearly_c4", 32'(bus.dataif_cpu_early_ready), 32'h1);
    chk("t2_crdyr_c4",  32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t2_drdyr_c4",  32'(bus.dataif_cpu_ready_r), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t2_drdyr_c5",  32'(bus.dataif_cpu_ready_r), 32'h1);

    // 3: wait-stated store locks the grant; mid-access code request waits
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2000_0104, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    chk("t3_en0",     32'(bus.tcm_en), 32'h1);
    chk("t3_addr0",   32'(bus.tcm_addr), 32'h104);
    chk("t3_din0",    bus.tcm_din, 32'hDEAD_BEEF);
    chk("t3_bsel0",   32'(bus.tcm_bytesel), 32'hF);
    chk("t3_dearly0", 32'(bus.dataif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0030, 1'b1, 32'h2000_0104, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    chk("t3_addr1",   32'(bus.tcm_addr), 32'h104);
    chk("t3_din1",    bus.tcm_din, 32'hDEAD_BEEF);
    chk("t3_cearly1", 32'(bus.codeif_cpu_early_ready), 32'h0);
    chk("t3_dearly1", 32'(bus.dataif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0030, 1'b1, 32'h2000_0104, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
    chk("t3_addr2",   32'(bus.tcm_addr), 32'h104);
    chk("t3_dearly2", 32'(bus.dataif_cpu_early_ready), 32'h1);
    chk("t3_cearly2", 32'(bus.codeif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0030, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t3_addr3",   32'(bus.tcm_addr), 32'h030);
    chk("t3_din3",    bus.tcm_din, 32'h0);
    chk("t3_bsel3",   32'(bus.tcm_bytesel), 32'h0);
    chk("t3_cearly3", 32'(bus.codeif_cpu_early_ready), 32'h1);
    chk("t3_drdyr3",  32'(bus.dataif_cpu_ready_r), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t3_crdyr4",  32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t3_drdyr4",  32'(bus.dataif_cpu_ready_r), 32'h0);

    // 4: code fetch with one wait state, then a data load; rdata routing
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    chk("t4_addr0",   32'(bus.tcm_addr), 32'h040);
    chk("t4_cearly0", 32'(bus.codeif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h2000_0300, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t4_addr1",   32'(bus.tcm_addr), 32'h040);
    chk("t4_cearly1", 32'(bus.codeif_cpu_early_ready), 32'h1);
    chk("t4_dearly1", 32'(bus.dataif_cpu_early_ready), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2000_0300, 32'h0, 4'h0, 1'b1, 32'hC0DE_0040);
    chk("t4_addr2",   32'(bus.tcm_addr), 32'h300);
    chk("t4_dearly2", 32'(bus.dataif_cpu_early_ready), 32'h1);
    chk("t4_crdata2", bus.codeif_cpu_rdata, 32'hC0DE_0040);
    chk("t4_drdata2", bus.dataif_cpu_rdata, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDA7A_0300);
    chk("t4_drdyr3",  32'(bus.dataif_cpu_ready_r), 32'h1);
    chk("t4_drdata3", bus.dataif_cpu_rdata, 32'hDA7A_0300);
    chk("t4_crdata3", bus.codeif_cpu_rdata, 32'h0);
    chk("t4_crdyr3",  32'(bus.codeif_cpu_ready_r), 32'h0);

    // 5: reset while data is wait-stated; pending code request wins afterwards
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0050, 1'b1, 32'h2000_0400, 32'h1234_5678, 4'h3, 1'b0, 32'h0);
      chk($sformatf("t5_addr_c%0d", i), 32'(bus.tcm_addr), 32'h400);
    end
    drive(1'b1, 1'b1, 32'h0000_0050, 1'b1, 32'h2000_0400, 32'h1234_5678, 4'h3, 1'b0, 32'h0);
    chk("t5_addr_rst", 32'(bus.tcm_addr), 32'h400);
    drive(1'b0, 1'b1, 32'h0000_0050, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF);
    chk("t5_addr4",   32'(bus.tcm_addr), 32'h050);
    chk("t5_cearly4", 32'(bus.codeif_cpu_early_ready), 32'h1);
    chk("t5_dearly4", 32'(bus.dataif_cpu_early_ready), 32'h0);
    chk("t5_drdyr4",  32'(bus.dataif_cpu_ready_r), 32'h0);
    chk("t5_drdata4", bus.dataif_cpu_rdata, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D);
    chk("t5_crdyr5",  32'(bus.codeif_cpu_ready_r), 32'h1);
    chk("t5_crdata5", bus.codeif_cpu_rdata, 32'h0BAD_F00D);

`ifdef NANORV32_TCM_ARB_STATS_EN
    // 6: conflict counter over five simultaneous-request cycles
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0060, 1'b1, 32'h2000_0500, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t6_cnt_rst", 32'(arb_conflict_cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0060, 1'b1, 32'h2000_0500, 32'h0, 4'h0, 1'b1, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t6_cnt_end", 32'(arb_conflict_cnt), 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("t6_cnt_hold", 32'(arb_conflict_cnt), 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
